rs_arb: RTL and testbench

RS_ARB -- requirements
Module: rs_arb

---
 rtl/rs_arb.sv | 160 ++++++++++++++++
 tb/tb_rs_arb.sv | 139 +++++++++++++
 2 files changed

// File: rtl/rs_arb.sv
// Round-robin arbiter sharing one RS decoder among NUM_CH byte-manager channels.
// The granted channel owns the decoder for one row, until it finishes or the watchdog expires.
module rs_arb #(
  parameter int NUM_CH = 2,
  parameter int DW     = 8,
  parameter int MW     = 2,
  parameter int TO_CYC = 65535,
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_CH-1:0]    ch_req,
  input  logic [NUM_CH*MW-1:0] ch_mode,
  input  logic [NUM_CH-1:0]    ch_en_in,
  input  logic [NUM_CH*DW-1:0] ch_din,
  input  logic                 rs_row_finish,
  input  logic                 rs_en_out,
  input  logic [DW-1:0]        rs_dout,
  output logic [NUM_CH-1:0]    ch_gnt,
  output logic [MW-1:0]        rs_mode,
  output logic                 rs_en_in,
  output logic [DW-1:0]        rs_din,
  output logic [NUM_CH-1:0]    ch_en_out,
  output logic [DW-1:0]        ch_dout,
  output logic [NUM_CH-1:0]    ch_done,
  output logic [NUM_CH-1:0]    ch_abort,
  output logic [CW-1:0]        owner,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  localparam logic [15:0]       WD_MAX = 16'(TO_CYC - 1);
  localparam logic [NUM_CH-1:0] ONE    = NUM_CH'(1);

  state_e              state_q, state_d;
  logic [CW-1:0]       rr_q, rr_d, own_q, own_d;
  logic [15:0]         wd_q, wd_d;
  logic [NUM_CH-1:0]   gnt_q, gnt_d, ceo_q, ceo_d, done_q, done_d, abort_q, abort_d;
  logic [MW-1:0]       mode_q, mode_d;
  logic                ei_q, ei_d, err_q, err_d;
  logic [DW-1:0]       di_q, di_d, cdo_q, cdo_d;

  logic                sel_vld;
  logic [CW-1:0]       sel_idx;
  logic [CW-1:0]       rr_nxt;
  logic                row_end;

  // Scan starting at rr_q with wrap; first requester wins.
  always_comb begin
    int c;
    c       = 0;
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = int'(rr_q) + k;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!sel_vld && ch_req[c]) begin
        sel_vld = 1'b1;
        sel_idx = CW'(c);
      end
    end
  end

  assign rr_nxt  = (own_q == CW'(NUM_CH - 1)) ? '0 : own_q + 1'b1;
  assign row_end = rs_row_finish || (wd_q == WD_MAX);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    wd_d    = wd_q;
    gnt_d   = gnt_q;
    own_d   = own_q;
    mode_d  = mode_q;
    ei_d    = 1'b0;
    di_d    = di_q;
    ceo_d   = '0;
    cdo_d   = cdo_q;
    done_d  = '0;
    abort_d = '0;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        // Decoder activity with no owner is dropped but flagged.
        if (rs_row_finish || rs_en_out) err_d = 1'b1;
        if (sel_vld) begin
          state_d = BUSY;
          gnt_d   = ONE << sel_idx;
          own_d   = sel_idx;
          mode_d  = ch_mode[sel_idx*MW +: MW];
          wd_d    = '0;
        end
      end
      BUSY: begin
        ei_d  = ch_en_in[own_q];
        di_d  = ch_din[own_q*DW +: DW];
        ceo_d = rs_en_out ? (ONE << own_q) : '0;
        cdo_d = rs_dout;
        wd_d  = wd_q + 16'd1;
        if (row_end) begin
          // Finish takes priority over a coincident watchdog expiry.
          state_d = IDLE;
          gnt_d   = '0;
          ei_d    = 1'b0;
          rr_d    = rr_nxt;
          wd_d    = '0;
          if (rs_row_finish) done_d  = ONE << own_q;
          else               abort_d = ONE << own_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      wd_q    <= '0;
      gnt_q   <= '0;
      own_q   <= '0;
      mode_q  <= '0;
      ei_q    <= 1'b0;
      di_q    <= '0;
      ceo_q   <= '0;
      cdo_q   <= '0;
      done_q  <= '0;
      abort_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      mode_q  <= mode_d;
      ei_q    <= ei_d;
      di_q    <= di_d;
      ceo_q   <= ceo_d;
      cdo_q   <= cdo_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      err_q   <= err_d;
    end
  end

  assign ch_gnt    = gnt_q;
  assign rs_mode   = mode_q;
  assign rs_en_in  = ei_q;
  assign rs_din    = di_q;
  assign ch_en_out = ceo_q;
  assign ch_dout   = cdo_q;
  assign ch_done   = done_q;
  assign ch_abort  = abort_q;
  assign owner     = own_q;
  assign busy      = (state_q == BUSY);
  assign err       = err_q;

endmodule

// File: tb/tb_rs_arb.sv
// Directed bench for rs_arb: 4 channels, 8-bit symbols, 16-cycle watchdog.
module tb_rs_arb;
  localparam int NUM_CH = 4;
  localparam int DW     = 8;
  localparam int MW     = 2;
  localparam int TO_CYC = 16;

  logic                 clk, reset_n;
  logic [NUM_CH-1:0]    ch_req, ch_en_in;
  logic [NUM_CH*MW-1:0] ch_mode;
  logic [NUM_CH*DW-1:0] ch_din;
  logic                 rs_row_finish, rs_en_out;
  logic [DW-1:0]        rs_dout;
  logic [NUM_CH-1:0]    ch_gnt, ch_en_out, ch_done, ch_abort;
  logic [MW-1:0]        rs_mode;
  logic                 rs_en_in, busy, err;
  logic [DW-1:0]        rs_din, ch_dout;
  logic [1:0]           owner;

  rs_arb #(.NUM_CH(NUM_CH), .DW(DW), .MW(MW), .TO_CYC(TO_CYC)) dut (
    .clk(clk), .reset_n(reset_n), .ch_req(ch_req), .ch_mode(ch_mode),
    .ch_en_in(ch_en_in), .ch_din(ch_din), .rs_row_finish(rs_row_finish),
    .rs_en_out(rs_en_out), .rs_dout(rs_dout), .ch_gnt(ch_gnt), .rs_mode(rs_mode),
    .rs_en_in(rs_en_in), .rs_din(rs_din), .ch_en_out(ch_en_out), .ch_dout(ch_dout),
    .ch_done(ch_done), .ch_abort(ch_abort), .owner(owner), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;  logic [7:0] mode; logic [3:0] en; logic [31:0] din;
    logic        fin;  logic eo;         logic [7:0] dout;
    logic [38:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  // {gnt, owner, busy, rs_mode, rs_en_in, rs_din, ch_en_out, ch_dout, ch_done, ch_abort, err}
  function automatic logic [38:0] outs();
    return {ch_gnt, owner, busy, rs_mode, rs_en_in, rs_din, ch_en_out, ch_dout,
            ch_done, ch_abort, err};
  endfunction

  task automatic add(input logic [3:0] req, input logic [7:0] mode, input logic [3:0] en,
                     input logic [31:0] din, input logic fin, input logic eo,
                     input logic [7:0] dout, input logic [3:0] gnt, input logic [1:0] own,
                     input logic bsy, input logic [1:0] mo, input logic ei,
                     input logic [7:0] di, input logic [3:0] ceo, input logic [7:0] cdo,
                     input logic [3:0] done);
    vec_t v;
    v.req = req; v.mode = mode; v.en = en; v.din = din; v.fin = fin; v.eo = eo; v.dout = dout;
    v.exp = {gnt, own, bsy, mo, ei, di, ceo, cdo, done, 4'b0000, 1'b0};
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ch0=01 ch1=10 ch2=11 ch3=00, later ch1 switches to 01
    add(4'b0011, 8'h39, 4'b0000, 32'h0,        0, 0, 8'h00, 4'b0001, 2'd0, 1, 2'b01, 0, 8'h00, 4'b0000, 8'h00, 4'b0000);
    add(4'b0011, 8'h39, 4'b0001, 32'h11,       0, 0, 8'h00, 4'b0001, 2'd0, 1, 2'b01, 1, 8'h11, 4'b0000, 8'h00, 4'b0000);
    add(4'b0011, 8'h39, 4'b0000, 32'h0,        1, 1, 8'h77, 4'b0000, 2'd0, 0, 2'b01, 0, 8'h00, 4'b0001, 8'h77, 4'b0001);
    add(4'b0011, 8'h39, 4'b0000, 32'h0,        0, 0, 8'h00, 4'b0010, 2'd1, 1, 2'b10, 0, 8'h00, 4'b0000, 8'h77, 4'b0000);
    add(4'b0110, 8'h35, 4'b0011, 32'h0000A53C, 0, 0, 8'h00, 4'b0010, 2'd1, 1, 2'b10, 1, 8'hA5, 4'b0000, 8'h00, 4'b0000);
    add(4'b0110, 8'h35, 4'b0000, 32'h0,        0, 1, 8'h5A, 4'b0010, 2'd1, 1, 2'b10, 0, 8'h00, 4'b0010, 8'h5A, 4'b0000);
    add(4'b0100, 8'h35, 4'b0000, 32'h0,        1, 1, 8'hC3, 4'b0000, 2'd1, 0, 2'b10, 0, 8'h00, 4'b0010, 8'hC3, 4'b0010);
    add(4'b0100, 8'h35, 4'b0000, 32'h0,        0, 0, 8'h00, 4'b0100, 2'd2, 1, 2'b11, 0, 8'h00, 4'b0000, 8'hC3, 4'b0000);
    add(4'b0000, 8'h35, 4'b0101, 32'h00A5003C, 0, 0, 8'h00, 4'b0100, 2'd2, 1, 2'b11, 1, 8'hA5, 4'b0000, 8'h00, 4'b0000);
    add(4'b0000, 8'h35, 4'b0000, 32'h0,        0, 1, 8'h5A, 4'b0100, 2'd2, 1, 2'b11, 0, 8'h00, 4'b0100, 8'h5A, 4'b0000);
    add(4'b0000, 8'h35, 4'b0000, 32'h0,        1, 0, 8'h00, 4'b0000, 2'd2, 0, 2'b11, 0, 8'h00, 4'b0000, 8'h00, 4'b0100);
    add(4'b1001, 8'h35, 4'b0000, 32'h0,        0, 0, 8'h00, 4'b1000, 2'd3, 1, 2'b00, 0, 8'h00, 4'b0000, 8'h00, 4'b0000);
    add(4'b1001, 8'h35, 4'b0000, 32'h0,        1, 0, 8'h00, 4'b0000, 2'd3, 0, 2'b00, 0, 8'h00, 4'b0000, 8'h00, 4'b1000);
    add(4'b1001, 8'h35, 4'b0000, 32'h0,        0, 0, 8'h00, 4'b0001, 2'd0, 1, 2'b01, 0, 8'h00, 4'b0000, 8'h00, 4'b0000);

    reset_n = 1'b0; ch_req = '0; ch_mode = '0; ch_en_in = '0; ch_din = '0;
    rs_row_finish = 1'b0; rs_en_out = 1'b0; rs_dout = '0;
    repeat (2) tick();
    chk("reset_state", 64'(outs()), 64'd0);
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      ch_req = tbl[i].req; ch_mode = tbl[i].mode; ch_en_in = tbl[i].en; ch_din = tbl[i].din;
      rs_row_finish = tbl[i].fin; rs_en_out = tbl[i].eo; rs_dout = tbl[i].dout;
      tick();
      chk($sformatf("vec%0d", i), 64'(outs()), 64'(tbl[i].exp));
    end

    // Watchdog: ch0 granted on the last vector, no finish follows.
    ch_req = '0; ch_en_in = '0; ch_din = '0; rs_row_finish = 1'b0; rs_en_out = 1'b0; rs_dout = '0;
    repeat (15) tick();
    chk("wd_before_expiry", 64'({busy, ch_gnt, ch_abort}), 64'({1'b1, 4'b0001, 4'b0000}));
    tick();
    chk("wd_abort", 64'({busy, ch_gnt, ch_abort, ch_done}), 64'({1'b0, 4'b0000, 4'b0001, 4'b0000}));
    ch_req = 4'b0001;
    tick();
    chk("wd_abort_one_cycle_regrant", 64'({ch_abort, ch_gnt, busy}), 64'({4'b0000, 4'b0001, 1'b1}));
    ch_req = '0;
    repeat (15) tick();
    rs_row_finish = 1'b1;
    tick();
    rs_row_finish = 1'b0;
    chk("wd_finish_wins", 64'({ch_done, ch_abort, busy}), 64'({4'b0001, 4'b0000, 1'b0}));

    // Decoder activity while idle
    rs_row_finish = 1'b1; rs_en_out = 1'b1; rs_dout = 8'hEE;
    tick();
    chk("idle_err_set", 64'({err, ch_done, busy, ch_en_out}), 64'({1'b1, 4'b0000, 1'b0, 4'b0000}));
    rs_row_finish = 1'b0; rs_en_out = 1'b0; rs_dout = '0;
    repeat (3) tick();
    chk("err_sticky", 64'({err, busy}), 64'({1'b1, 1'b0}));

    // Reset mid-row
    ch_req = 4'b1111;
    tick();
    chk("grant_ch1_after_rr", 64'({ch_gnt, owner}), 64'({4'b0010, 2'd1}));
    tick();
    #1 reset_n = 1'b0;
    #1 chk("async_reset_mid_row", 64'(outs()), 64'd0);
    #1 reset_n = 1'b1;
    tick();
    chk("first_grant_after_reset", 64'({ch_gnt, owner, busy, rs_mode, ch_done, ch_abort}),
        64'({4'b0001, 2'd0, 1'b1, 2'b01, 4'b0000, 4'b0000}));

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
